// File: rtl/mem_access_unit_if.sv
// Bundle between the M-stage pipeline, the memory access unit and external memory.
// The slave modport is the unit's view; master is the surrounding environment.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] WriteDataM;
  logic                  MemWriteM;
  logic [1:0]            ResultSrcM;
  logic [2:0]            MemCtrlM;
  logic                  MemReq;
  logic                  MemWe;
  logic [DATA_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0] MemWData;
  logic [3:0]            MemBe;
  logic                  MemAck;
  logic [DATA_WIDTH-1:0] MemRData;
  logic [DATA_WIDTH-1:0] ReadDataM;
  logic                  StallM;
  logic                  MisalignM;

  modport slave (
    input  ALUResultM, WriteDataM, MemWriteM, ResultSrcM, MemCtrlM, MemAck, MemRData,
    output MemReq, MemWe, MemAddr, MemWData, MemBe, ReadDataM, StallM, MisalignM
  );

  modport master (
    output ALUResultM, WriteDataM, MemWriteM, ResultSrcM, MemCtrlM, MemAck, MemRData,
    input  MemReq, MemWe, MemAddr, MemWData, MemBe, ReadDataM, StallM, MisalignM
  );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: aligns byte/half/word accesses onto a word-wide memory
// with a req/ack handshake, stalling the pipeline until the access completes.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                r_state;
  logic                  r_req;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_be;
  logic [2:0]            r_ctrl;
  logic [1:0]            r_off;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_misalign;

  logic                  w_valid;
  logic                  w_mis;
  logic                  w_start;
  logic [1:0]            w_off;

  // Size code low bits: 00 byte, 01 half, anything else behaves as a word.
  function automatic logic f_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl[1:0])
      2'b00:   f_misaligned = 1'b0;
      2'b01:   f_misaligned = off[0];
      default: f_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl[1:0])
      2'b00:   f_be = 4'b0001 << off;
      2'b01:   f_be = 4'b0011 << off;
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_wdata(input logic [2:0] ctrl,
                                                    input logic [DATA_WIDTH-1:0] d);
    case (ctrl[1:0])
      2'b00:   f_wdata = {4{d[7:0]}};
      2'b01:   f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_load(input logic [2:0] ctrl, input logic [1:0] off,
                                                   input logic [DATA_WIDTH-1:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (ctrl)
      3'b000:  f_load = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b100:  f_load = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b001:  f_load = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b101:  f_load = {{(DATA_WIDTH-16){1'b0}}, h};
      default: f_load = rd;
    endcase
  endfunction

  assign w_off   = bus.ALUResultM[1:0];
  assign w_valid = bus.MemWriteM | (bus.ResultSrcM == 2'b01);
  assign w_mis   = f_misaligned(bus.MemCtrlM, w_off);
  assign w_start = (r_state == IDLE) & w_valid & ~w_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= 4'b0000;
      r_ctrl     <= 3'b000;
      r_off      <= 2'b00;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid && w_mis) begin
            r_misalign <= 1'b1;
          end else if (w_valid) begin
            r_req   <= 1'b1;
            r_we    <= bus.MemWriteM;
            r_addr  <= {bus.ALUResultM[DATA_WIDTH-1:2], 2'b00};
            r_wdata <= f_wdata(bus.MemCtrlM, bus.WriteDataM);
            r_be    <= f_be(bus.MemCtrlM, w_off);
            r_ctrl  <= bus.MemCtrlM;
            r_off   <= w_off;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.MemAck) begin
            r_req   <= 1'b0;
            if (!r_we) r_rdata <= f_load(r_ctrl, r_off, bus.MemRData);
            r_state <= DONE;
          end
        end
        // One free cycle lets the frozen E/M register advance before the next accept.
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.MemReq    = r_req;
  assign bus.MemWe     = r_we;
  assign bus.MemAddr   = r_addr;
  assign bus.MemWData  = r_wdata;
  assign bus.MemBe     = r_be;
  assign bus.ReadDataM = r_rdata;
  assign bus.MisalignM = r_misalign;
  assign bus.StallM    = ~rst & ((r_state == BUSY) | w_start);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected requests and load results are queued
// when an access is driven and compared when the memory handshake completes.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;

  mem_access_unit_if #(.DATA_WIDTH(32)) bus ();

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        q_req[$];
  logic [31:0] q_rd[$];
  logic [31:0] exp_rd_hold;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [1:0] rs, input logic [2:0] ct);
    bus.ALUResultM = a;
    bus.WriteDataM = wd;
    bus.MemWriteM  = we;
    bus.ResultSrcM = rs;
    bus.MemCtrlM   = ct;
  endtask

  task automatic set_idle();
    set_in(32'h0, 32'h0, 1'b0, 2'b00, 3'b010);
  endtask

  // Drives one access, serves it after lat non-ack BUSY cycles, checks through DONE.
  task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [2:0] ct, input logic [31:0] rdata,
                        input int lat, input logic [3:0] be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    req_t        e;
    req_t        got;
    logic [31:0] rd_exp;
    int          stalls;
    int          waited;
    stalls = 0;
    waited = 0;
    tick();
    set_in(a, wd, we, we ? 2'b00 : 2'b01, ct);
    e.addr  = {a[31:2], 2'b00};
    e.we    = we;
    e.be    = be;
    e.wdata = exp_wd;
    q_req.push_back(e);
    if (!we) exp_rd_hold = exp_rd;
    q_rd.push_back(exp_rd_hold);
    settle();
    chk({tag, " idle_stall"}, {31'b0, bus.StallM}, 32'd1);
    chk({tag, " idle_req"}, {31'b0, bus.MemReq}, 32'd0);
    if (bus.StallM) stalls++;
    tick();
    while (!bus.MemReq && waited < 8) begin
      waited++;
      tick();
    end
    chk({tag, " req_seen"}, {31'b0, bus.MemReq}, 32'd1);
    got    = q_req.pop_front();
    rd_exp = q_rd.pop_front();
    if (!bus.MemReq) return;
    for (int i = 0; i <= lat; i++) begin
      bus.MemAck   = (i == lat);
      bus.MemRData = (i == lat) ? rdata : 32'h0BAD_0BAD;
      settle();
      chk({tag, " addr"}, bus.MemAddr, got.addr);
      chk({tag, " we"}, {31'b0, bus.MemWe}, {31'b0, got.we});
      chk({tag, " be"}, {28'b0, bus.MemBe}, {28'b0, got.be});
      chk({tag, " wdata"}, bus.MemWData, got.wdata);
      chk({tag, " busy_req"}, {31'b0, bus.MemReq}, 32'd1);
      if (bus.StallM) stalls++;
      tick();
    end
    bus.MemAck   = 1'b0;
    bus.MemRData = 32'h0;
    settle();
    chk({tag, " done_stall"}, {31'b0, bus.StallM}, 32'd0);
    chk({tag, " done_req"}, {31'b0, bus.MemReq}, 32'd0);
    chk({tag, " rdata"}, bus.ReadDataM, rd_exp);
    chk({tag, " stall_cycles"}, stalls, lat + 2);
  endtask

  initial begin
    rst          = 1'b1;
    exp_rd_hold  = 32'h0;
    bus.MemAck   = 1'b0;
    bus.MemRData = 32'h0;
    set_idle();
    tick();
    chk("rst MemReq", {31'b0, bus.MemReq}, 32'd0);
    chk("rst MemWe", {31'b0, bus.MemWe}, 32'd0);
    chk("rst MemAddr", bus.MemAddr, 32'h0);
    chk("rst MemWData", bus.MemWData, 32'h0);
    chk("rst MemBe", {28'b0, bus.MemBe}, 32'h0);
    chk("rst ReadDataM", bus.ReadDataM, 32'h0);
    chk("rst MisalignM", {31'b0, bus.MisalignM}, 32'd0);
    chk("rst StallM", {31'b0, bus.StallM}, 32'd0);
    rst = 1'b0;

    access("sw", 32'h104, 32'hDEADBEEF, 1'b1, 3'b010, 32'h0, 1, 4'b1111, 32'hDEADBEEF, 32'h0);
    tick(); set_idle();
    access("lb", 32'h203, 32'h0, 1'b0, 3'b000, 32'h80FFFFFF, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
    tick(); set_idle();
    access("lbu", 32'h203, 32'h0, 1'b0, 3'b100, 32'h80FFFFFF, 0, 4'b1000, 32'h0, 32'h00000080);
    tick(); set_idle();
    access("sh", 32'h12, 32'h0000ABCD, 1'b1, 3'b001, 32'h0, 0, 4'b1100, 32'hABCDABCD, 32'h0);
    tick(); set_idle();
    access("lh", 32'h202, 32'h0, 1'b0, 3'b001, 32'h80FF1234, 2, 4'b1100, 32'h0, 32'hFFFF80FF);
    tick(); set_idle();
    access("lhu", 32'h202, 32'h0, 1'b0, 3'b101, 32'h80FF1234, 0, 4'b1100, 32'h0, 32'h000080FF);
    tick(); set_idle();
    access("sb", 32'h101, 32'h0000005A, 1'b1, 3'b000, 32'h0, 0, 4'b0010, 32'h5A5A5A5A, 32'h0);
    tick(); set_idle();
    access("sw_rsvd", 32'h20, 32'h12345678, 1'b1, 3'b011, 32'h0, 0, 4'b1111, 32'h12345678, 32'h0);
    tick(); set_idle();

    // Misaligned word load: no request, no stall, registered one-cycle pulse.
    tick();
    set_in(32'h101, 32'h0, 1'b0, 2'b01, 3'b010);
    settle();
    chk("mis stall", {31'b0, bus.StallM}, 32'd0);
    chk("mis req0", {31'b0, bus.MemReq}, 32'd0);
    tick(); set_idle(); settle();
    chk("mis pulse", {31'b0, bus.MisalignM}, 32'd1);
    chk("mis req1", {31'b0, bus.MemReq}, 32'd0);
    chk("mis stall1", {31'b0, bus.StallM}, 32'd0);
    tick(); settle();
    chk("mis pulse_end", {31'b0, bus.MisalignM}, 32'd0);
    chk("mis req2", {31'b0, bus.MemReq}, 32'd0);

    // Non-access instruction passes straight through.
    tick();
    set_in(32'h300, 32'h55, 1'b0, 2'b10, 3'b010);
    settle();
    chk("nop stall", {31'b0, bus.StallM}, 32'd0);
    tick(); set_idle(); settle();
    chk("nop req", {31'b0, bus.MemReq}, 32'd0);

    // Reset while BUSY, then a stale ack after release.
    tick();
    set_in(32'h40, 32'h0, 1'b0, 2'b01, 3'b010);
    settle();
    chk("rbusy stall", {31'b0, bus.StallM}, 32'd1);
    tick(); settle();
    chk("rbusy req", {31'b0, bus.MemReq}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rbusy req_clr", {31'b0, bus.MemReq}, 32'd0);
    chk("rbusy stall_clr", {31'b0, bus.StallM}, 32'd0);
    chk("rbusy rdata_clr", bus.ReadDataM, 32'h0);
    tick();
    rst = 1'b0;
    set_idle();
    bus.MemAck   = 1'b1;
    bus.MemRData = 32'hFFFFFFFF;
    settle();
    chk("rbusy late_req", {31'b0, bus.MemReq}, 32'd0);
    tick();
    bus.MemAck   = 1'b0;
    bus.MemRData = 32'h0;
    settle();
    chk("rbusy late_rdata", bus.ReadDataM, 32'h0);
    chk("rbusy late_stall", {31'b0, bus.StallM}, 32'd0);
    chk("rbusy late_req2", {31'b0, bus.MemReq}, 32'd0);
    exp_rd_hold = 32'h0;

    // Back-to-back loads: the second is accepted only after the first one's DONE cycle.
    access("lw0", 32'h0, 32'h0, 1'b0, 3'b010, 32'h11111111, 0, 4'b1111, 32'h0, 32'h11111111);
    access("lw4", 32'h4, 32'h0, 1'b0, 3'b010, 32'h22222222, 0, 4'b1111, 32'h0, 32'h22222222);
    tick(); set_idle(); settle();
    chk("b2b no_extra_req", {31'b0, bus.MemReq}, 32'd0);
    tick(); settle();
    chk("b2b no_extra_req2", {31'b0, bus.MemReq}, 32'd0);
    chk("b2b queue_empty", q_req.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, datapath width; all behaviour below is defined for 32.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ALUResultM  in  32  effective byte address from the E/M register.
REQ-005 WriteDataM  in  32  store data, right-justified.
REQ-006 MemWriteM  in  1  store request.
REQ-007 ResultSrcM  in  2  value 2'b01 marks a load.
REQ-008 MemCtrlM  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 MemReq  out  1  external memory request, held until MemAck.
REQ-010 MemWe  out  1  request is a write.
REQ-011 MemAddr  out  32  word address; bits [1:0] always 0.
REQ-012 MemWData  out  32  store data shifted into its byte lanes.
REQ-013 MemBe  out  4  byte-lane enables.
REQ-014 MemAck  in  1  memory completes the request this cycle; MemRData is valid with it.
REQ-015 MemRData  in  32  read word.
REQ-016 ReadDataM  out  32  extended load result, registered.
REQ-017 StallM  out  1  freeze the F/D/E stages and the E/M register.
REQ-018 MisalignM  out  1  one-cycle pulse on a misaligned access.

Function
REQ-019 Access valid = MemWriteM | (ResultSrcM==2'b01); a non-access passes through with StallM=0 and no request.
REQ-020 Misaligned = (H/HU and addr[0]) or (W and addr[1:0]!=0); a misaligned access pulses MisalignM for one cycle, issues no request, and does not stall.
REQ-021 Reserved MemCtrlM codes (011, 110, 111) are treated as W.
REQ-022 FSM states: IDLE, BUSY, DONE.
REQ-023 IDLE + valid aligned access: StallM=1 combinationally, latch MemAddr/MemWe/MemWData/MemBe, assert MemReq at the next edge, go to BUSY.
REQ-024 BUSY: MemReq=1 and StallM=1, with all request outputs held stable until the cycle MemAck=1.
REQ-025 BUSY + MemAck: deassert MemReq at the edge, register the extended load data into ReadDataM (stores leave ReadDataM unchanged), go to DONE.
REQ-026 DONE: StallM=0 for exactly one cycle so the pipeline advances, then go to IDLE unconditionally; no new access is accepted in DONE.
REQ-027 MemBe: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111; loads drive the same pattern.
REQ-028 MemWData: B replicates WriteDataM[7:0] into all four lanes; H replicates [15:0] into both halves; W passes the word through.
REQ-029 Load extract: byte/half selected by addr[1:0]; B/H sign-extend; BU/HU zero-extend; W is unmodified.
REQ-030 MemAck outside BUSY is ignored.
REQ-031 Minimum access latency: 3 cycles (IDLE, BUSY with ack, DONE); every cycle MemAck is late adds one BUSY cycle.

Reset
REQ-032 rst=1 forces IDLE immediately and drives MemReq=0, MemWe=0, MemAddr=0, MemWData=0, MemBe=0, ReadDataM=0, MisalignM=0, StallM=0.
REQ-033 Reset during BUSY abandons the request with no completion; a MemAck arriving after release is ignored.

Verification
REQ-034 Directed scenarios the bench SHALL cover:
- SW addr 0x104, data 0xDEADBEEF, ack after 2 BUSY cycles -> MemAddr 0x104, MemBe 1111, MemWData 0xDEADBEEF, StallM high 3 cycles, then one DONE cycle.
- LB addr 0x203, MemRData 0x80FF_FF_FF, immediate ack -> MemBe 1000, ReadDataM 0xFFFFFF80; the same access as LBU -> 0x00000080.
- SH addr 0x12, data 0x0000ABCD -> MemBe 1100, MemWData 0xABCDABCD.
- LW addr 0x101 -> MisalignM pulses for one cycle, MemReq stays 0, StallM stays 0.
- rst asserted in BUSY, then ack after release -> MemReq 0 immediately, state IDLE, ReadDataM 0.
- Back-to-back LW 0x0 then LW 0x4, both with immediate ack -> two distinct requests separated by a DONE cycle, and no duplicate request for the first load.
